// File: rtl/reg_bank_phased.sv
// Register bank with two registered read ports and one write port, driven by an
// internal read/execute/writeback phase sequencer and a hardware clear sweep.
module reg_bank_phased #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              clr_req,
    output logic [1:0]        phase,
    output logic [DATA_W-1:0] source1,
    output logic [DATA_W-1:0] source2,
    output logic              busy
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rd_fire;
    logic              wr_fire;
    logic [DATA_W-1:0] rd_val1, rd_val2;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    phase_d = '0;
                    ptr_d   = '0;
                end else begin
                    phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                end
            end
            SWEEP: begin
                phase_d = '0;
                ptr_d   = ptr_q + ADDR_W'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clr_req takes priority over a same-edge writeback.
    always_comb begin
        busy    = (state_q == SWEEP);
        phase   = phase_q;
        rd_fire = (state_q == IDLE) && (phase_q == 2'd0);
        wr_fire = (state_q == IDLE) && (phase_q == 2'd2) && wr_en && !clr_req
                  && !(ZERO_REG && (wr_addr == '0));
        rd_val1 = (ZERO_REG && (rd_addr1 == '0)) ? '0 : mem_q[rd_addr1];
        rd_val2 = (ZERO_REG && (rd_addr2 == '0)) ? '0 : mem_q[rd_addr2];
        source1 = src1_q;
        source2 = src2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            src1_q <= '0;
            src2_q <= '0;
        end else if (rd_fire) begin
            src1_q <= rd_val1;
            src2_q <= rd_val2;
        end
    end

    // Array has no reset; only the sweep clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == SWEEP) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_fire) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

endmodule
